// File: rtl/adder_arb.sv
// adder_arb: two clients share one W+1-bit adder through a round-robin arbiter.
// A grant is held for as long as its owner keeps requesting. When the owner
// releases while the other client is waiting, ownership hands over on the
// same edge.
module adder_arb #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic         req1,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    output logic         gnt0,
    output logic         gnt1,
    output logic [W:0]   sum_out,
    output logic         busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    logic [1:0]   state_q, state_d;
    logic         last_q, last_d;
    logic [W-1:0] op_a, op_b;

    // Next-state arbitration: the owner keeps the adder while it requests; on a tie in IDLE, the client not served last wins.
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE: begin
                if (req0 && req1) state_d = last_q ? OWN0 : OWN1;
                else if (req0)    state_d = OWN0;
                else if (req1)    state_d = OWN1;
                else              state_d = IDLE;
            end
            OWN0: begin
                if (req0)      state_d = OWN0;
                else if (req1) state_d = OWN1;
                else           state_d = IDLE;
            end
            OWN1: begin
                if (req1)      state_d = OWN1;
                else if (req0) state_d = OWN0;
                else           state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Round-robin pointer: remember whichever client is entering ownership.
    always_comb begin
        last_d = last_q;
        if (state_d == OWN0 && state_q != OWN0) last_d = 1'b0;
        if (state_d == OWN1 && state_q != OWN1) last_d = 1'b1;
    end

    // State and pointer registers. Reset leaves last=1 so client 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Operand mux: only the owner's operands reach the adder; IDLE feeds zeros.
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (state_q)
            OWN0: begin
                op_a = a0;
                op_b = b0;
            end
            OWN1: begin
                op_a = a1;
                op_b = b1;
            end
            default: begin
                op_a = '0;
                op_b = '0;
            end
        endcase
    end

    assign sum_out = {1'b0, op_a} + {1'b0, op_b};
    assign gnt0    = (state_q == OWN0);
    assign gnt1    = (state_q == OWN1);
    assign busy    = gnt0 | gnt1;

endmodule

// File: doc/adder_arb.md
ADDER_ARB -- requirements
Module: adder_arb

Interface
REQ-001 The block SHALL have the parameter W, default 8, giving the adder operand width.
REQ-002 The block SHALL have the port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have the port req0, input, 1 bit, the client 0 request; it is held high for the whole adder-use sequence.
REQ-005 The block SHALL have the port a0, input, W bits, client 0 operand A.
REQ-006 The block SHALL have the port b0, input, W bits, client 0 operand B.
REQ-007 The block SHALL have the ports req1, a1 and b1, with the same widths and meanings as req0, a0 and b0, for client 1.
REQ-008 The block SHALL have the port gnt0, output, 1 bit, registered; client 0 owns the adder.
REQ-009 The block SHALL have the port gnt1, output, 1 bit, registered; client 1 owns the adder.
REQ-010 The block SHALL have the port sum_out, output, W+1 bits, combinational; it is broadcast to both clients.
REQ-011 The block SHALL have the port busy, output, 1 bit; busy = gnt0 | gnt1.

Function
REQ-012 The FSM SHALL have the states IDLE, OWN0 and OWN1, with gnt0 = (state==OWN0) and gnt1 = (state==OWN1).
REQ-013 The block SHALL hold a round-robin register `last` (1 bit) naming the client served most recently.
REQ-014 In IDLE with only reqN high, the FSM SHALL go to OWNN on the next edge, so gntN rises 1 cycle after reqN is sampled high.
REQ-015 In IDLE with both requests high, the FSM SHALL grant client (~last).
REQ-016 In IDLE with no request, the FSM SHALL stay in IDLE.
REQ-017 In OWNN with reqN high, the FSM SHALL stay in OWNN regardless of the other request, with no preemption and no timeout.
REQ-018 In OWNN with reqN low and the other request high, the FSM SHALL go directly to the other OWN state in one edge, with no IDLE bubble.
REQ-019 In OWNN with reqN low and the other request low, the FSM SHALL go to IDLE.
REQ-020 On every entry into OWNN, `last` SHALL be set to N.
REQ-021 gnt0 and gnt1 SHALL never be high in the same cycle.
REQ-022 The operand mux SHALL select (a0,b0) in OWN0, (a1,b1) in OWN1, and (0,0) in IDLE.
REQ-023 sum_out SHALL equal the zero-extended sum of the selected operands, using a single W+1-bit adder with the carry in bit W and no wrap.
REQ-024 sum_out SHALL be valid in the same cycle the operands are applied; a client registers sum_out on the edge after it drives its operands.
REQ-025 Operands from a client without a grant SHALL have no effect on sum_out.
REQ-026 A request dropped and re-raised in the same client SHALL be treated as a new request and arbitrated against the other client.
REQ-027 A client dropping reqN in the cycle gntN would rise SHALL still receive one cycle of grant, then the normal release rules SHALL apply.

Reset
REQ-028 While rst is high at an edge, the FSM SHALL go to IDLE and `last` SHALL be set to 1, so client 0 wins the first tie.
REQ-029 After reset, gnt0=0, gnt1=0, busy=0, and sum_out=0 (IDLE mux).
REQ-030 Reset asserted while a client owns the adder SHALL drop the grant on that edge, and the client SHALL re-request afterwards.
REQ-031 rst SHALL take priority over all requests.

Verification
REQ-032 The bench SHALL check single client: rst, then req0=1 with a0=200 and b0=100 -> gnt0=1 after 1 cycle, sum_out=300; req0=0 -> gnt0=0 and sum_out=0 next cycle.
REQ-033 The bench SHALL check a tie after reset: req0=req1=1 in the same cycle -> gnt0 first; on req0 release, gnt1=1 on the very next edge with no idle cycle.
REQ-034 The bench SHALL check round robin: after client 0 is served alone, both request from IDLE -> gnt1 wins; then repeat with client 1 served -> gnt0 wins.
REQ-035 The bench SHALL check no preemption: client 1 holds for 20 cycles while req0=1 -> gnt0 stays 0 throughout, a1/b1 alone drive sum_out, and a0=255, b0=255 never appear.
REQ-036 The bench SHALL check reset mid-ownership: gnt1=1, then rst for 1 cycle -> gnt1=0 and busy=0; with req1 still high and rst low, gnt1 returns 1 cycle later.
REQ-037 The bench SHALL check overflow: a0=255, b0=255 under grant -> sum_out=510, with the carry bit set.
REQ-038 The bench SHALL check mutual exclusion: random req0/req1 over 10000 cycles -> gnt0&gnt1 never 1, and every held request is granted within one ownership period of the other client.
